msg_sched_stream: RTL
=====================

Name: msg_sched_stream

Overview:
- Sequential, parametrised SHA-2 message-schedule generator for the cryptographic accelerator.
- Accepts one 16-word message block over a valid/ready load port.
- Streams the schedule words W_0..W_{ROUNDS-1} to the compression round over a valid/ready output port, one word per handshake.
- Generalises the single-word combinational expansion step to a 16-entry sliding window, selectable SHA-256 (32-bit) or SHA-512 (64-bit) operation, and full back-pressure support.

Parameters:
- WIDTH, 32: word width. Legal values are 32 (SHA-256 sigma constants) and 64 (SHA-512 sigma constants). Any other value is an elaboration error.
- ROUNDS, 64: number of schedule words emitted per block. Use 64 for SHA-256 and 80 for SHA-512. Must be >= 16.
- CNT_W, $clog2(ROUNDS): width of the round index.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- msg_valid_i  in  1  load word valid
- msg_ready_o  out  1  load word accepted when high with msg_valid_i
- msg_word_i  in  WIDTH  message word; word 0 is sent first
- w_valid_o  out  1  schedule word valid
- w_ready_i  in  1  consumer accepts schedule word
- w_o  out  WIDTH  schedule word W_t
- w_idx_o  out  CNT_W  index t of w_o
- busy_o  out  1  high while in EXPAND
- done_o  out  1  one-cycle pulse after W_{ROUNDS-1} is accepted
- abort_i  in  1  present only with MSGSCHED_ABORT_EN

Behaviour:
- Reset is synchronous and active-high, sampled on the rising edge of clk_i. It puts the block in LOAD and clears load_cnt, t, the window registers and done_o.
  - Output values while in reset and after it: msg_ready_o=1, w_valid_o=0, w_o=0, w_idx_o=0, busy_o=0, done_o=0.
- Storage: window[0..15] of WIDTH bits each. w_o = window[0] and w_idx_o = t, both driven directly from registers.
- State LOAD:
  - msg_ready_o=1, w_valid_o=0.
  - Each load handshake shifts the window down (window[i] <= window[i+1]), writes msg_word_i into window[15] and increments load_cnt.
  - On the 16th handshake: load_cnt <= 0, t <= 0, next state EXPAND.
- State EXPAND:
  - msg_ready_o=0, w_valid_o=1, busy_o=1.
  - First word: W_0 is valid in the cycle after the 16th load handshake (latency 1).
  - On each output handshake, the window shifts down and window[15] <= new, where new = sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0], taken mod 2^WIDTH.
    - The sum is computed as two carry-save stages followed by one carry-propagate add.
    - Words are emitted for t < 16 as well; those new values equal W_{t+16}.
  - Without a handshake (w_ready_i=0), the window, t, w_o and w_idx_o hold stable. w_valid_o is never retracted.
  - When the handshake occurs at t=ROUNDS-1: next state LOAD, t <= 0, and done_o=1 in the following cycle for exactly one cycle.
- Sigma functions, WIDTH=32:
  - sigma0 = ROTR7 ^ ROTR18 ^ SHR3
  - sigma1 = ROTR17 ^ ROTR19 ^ SHR10
- Sigma functions, WIDTH=64:
  - sigma0 = ROTR1 ^ ROTR8 ^ SHR7
  - sigma1 = ROTR19 ^ ROTR61 ^ SHR6
- Simultaneous events:
  - msg_valid_i during EXPAND is ignored, because msg_ready_o=0.
  - In the cycle done_o is high the block is already in LOAD and may accept a load word.
- Reset mid-load or mid-expand: return to the LOAD reset state in the next cycle. Partial data is discarded and no done_o pulse is produced.

Optional Feature:
- Macro: MSGSCHED_ABORT_EN.
- When defined:
  - Port abort_i exists.
  - abort_i=1 in any state forces LOAD, clears load_cnt and t, and suppresses done_o.
  - abort_i has priority over any handshake in the same cycle. rst_i still has priority over abort_i.
- When undefined: no abort_i port, and an in-flight block can only be terminated by rst_i.

Test Plan:
- SHA-256 "abc" (WIDTH=32): load W0=0x61626380, W1..W14=0, W15=0x00000018 with w_ready_i=1 -> w_o sequence starts 0x61626380, 0,..., 0x18; W16=0x61626380, W17=0x000F0000; exactly 64 words emitted; done_o pulses once, 1 cycle after the t=63 handshake.
- Back-pressure: same block, w_ready_i toggled by a random pattern -> identical word/index sequence; w_o and w_idx_o stable while w_valid_o=1 and w_ready_i=0.
- SHA-512 (WIDTH=64, ROUNDS=80): W0=0x6162638000000000, W15=0x18, others 0 -> W16=0x6162638000000000, W17=0x00030000000000C0; 80 words emitted, then done_o.
- Load gaps: msg_valid_i asserted only every third cycle -> first w_valid_o in the cycle after the 16th handshake; msg_valid_i during EXPAND not accepted.
- Reset at t=30 -> next cycle msg_ready_o=1, w_valid_o=0, no done_o pulse; a fresh "abc" block then reproduces the sequence from the first scenario.
- With MSGSCHED_ABORT_EN: abort_i at load_cnt=7 and again at t=40 -> LOAD state, no done_o; back-to-back block loads immediately after the abort are correct.

Source files
------------

// File: rtl/msg_sched_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : msg_sched_stream_if
// Description : Load and schedule-stream handshake bundle for the SHA-2
//               message-schedule generator. The abort_i signal exists only
//               when MSGSCHED_ABORT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface msg_sched_stream_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
);
    logic             msg_valid_i;
    logic             msg_ready_o;
    logic [WIDTH-1:0] msg_word_i;
    logic             w_valid_o;
    logic             w_ready_i;
    logic [WIDTH-1:0] w_o;
    logic [CNT_W-1:0] w_idx_o;
    logic             busy_o;
    logic             done_o;
`ifdef MSGSCHED_ABORT_EN
    logic             abort_i;
`endif

    // Producer / consumer side of the scheduler
    modport master (
`ifdef MSGSCHED_ABORT_EN
        output abort_i,
`endif
        output msg_valid_i,
        output msg_word_i,
        output w_ready_i,
        input  msg_ready_o,
        input  w_valid_o,
        input  w_o,
        input  w_idx_o,
        input  busy_o,
        input  done_o
    );

    // Scheduler side
    modport slave (
`ifdef MSGSCHED_ABORT_EN
        input  abort_i,
`endif
        input  msg_valid_i,
        input  msg_word_i,
        input  w_ready_i,
        output msg_ready_o,
        output w_valid_o,
        output w_o,
        output w_idx_o,
        output busy_o,
        output done_o
    );
endinterface
`default_nettype wire

// File: rtl/msg_sched_stream.sv
`default_nettype none
// ============================================================================
// Module      : msg_sched_stream
// Description : Sequential SHA-2 message-schedule generator. Loads a 16-word
//               block, then streams W_0..W_{ROUNDS-1} from a 16-entry sliding
//               window with full back-pressure. WIDTH=32 selects SHA-256
//               sigma functions, WIDTH=64 selects SHA-512.
//               Optional feature macro: MSGSCHED_ABORT_EN (adds abort_i).
// Revision    : 1.0 - initial release
// ============================================================================
module msg_sched_stream #(
    parameter int WIDTH  = 32,
    parameter int ROUNDS = 64,
    parameter int CNT_W  = $clog2(ROUNDS)
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    msg_sched_stream_if.slave bus
);

    localparam logic [0:0]       c_ST_LOAD   = 1'b0;
    localparam logic [0:0]       c_ST_EXPAND = 1'b1;
    localparam logic [CNT_W-1:0] c_LAST_T    = CNT_W'(ROUNDS - 1);

    logic [0:0]       r_state;
    logic [3:0]       r_load_cnt;
    logic [CNT_W-1:0] r_t;
    logic [WIDTH-1:0] r_win [16];
    logic             r_done;

    logic             w_abort;
    logic             w_load_hs;
    logic             w_out_hs;
    logic [WIDTH-1:0] w_sig0_in;
    logic [WIDTH-1:0] w_sig1_in;
    logic [WIDTH-1:0] w_s0;
    logic [WIDTH-1:0] w_s1;
    logic [WIDTH-1:0] w_csa1_sum;
    logic [WIDTH-1:0] w_csa1_maj;
    logic [WIDTH-1:0] w_csa1_car;
    logic [WIDTH-1:0] w_csa2_sum;
    logic [WIDTH-1:0] w_csa2_maj;
    logic [WIDTH-1:0] w_csa2_car;
    logic [WIDTH-1:0] w_new;
    logic [WIDTH-1:0] w_fill;

    if (ROUNDS < 16) begin : g_bad_rounds
        $error("msg_sched_stream: ROUNDS must be at least 16");
    end

`ifdef MSGSCHED_ABORT_EN
    assign w_abort = bus.abort_i;
`else
    assign w_abort = 1'b0;
`endif

    // Abort beats any handshake in the same cycle
    assign w_load_hs = (r_state == c_ST_LOAD)   && bus.msg_valid_i && !w_abort;
    assign w_out_hs  = (r_state == c_ST_EXPAND) && bus.w_ready_i   && !w_abort;

    assign w_sig0_in = r_win[1];
    assign w_sig1_in = r_win[14];

    if (WIDTH == 32) begin : g_sha256
        assign w_s0 = {w_sig0_in[6:0],  w_sig0_in[WIDTH-1:7]}
                    ^ {w_sig0_in[17:0], w_sig0_in[WIDTH-1:18]}
                    ^ (w_sig0_in >> 3);
        assign w_s1 = {w_sig1_in[16:0], w_sig1_in[WIDTH-1:17]}
                    ^ {w_sig1_in[18:0], w_sig1_in[WIDTH-1:19]}
                    ^ (w_sig1_in >> 10);
    end else if (WIDTH == 64) begin : g_sha512
        assign w_s0 = {w_sig0_in[0:0],  w_sig0_in[WIDTH-1:1]}
                    ^ {w_sig0_in[7:0],  w_sig0_in[WIDTH-1:8]}
                    ^ (w_sig0_in >> 7);
        assign w_s1 = {w_sig1_in[18:0], w_sig1_in[WIDTH-1:19]}
                    ^ {w_sig1_in[60:0], w_sig1_in[WIDTH-1:61]}
                    ^ (w_sig1_in >> 6);
    end else begin : g_bad_width
        $error("msg_sched_stream: WIDTH must be 32 or 64");
        assign w_s0 = '0;
        assign w_s1 = '0;
    end

    // Two carry-save stages reduce the four addends to two; the shifted-out
    // carry MSB is discarded since the result is taken mod 2^WIDTH.
    assign w_csa1_sum = w_s1 ^ r_win[9] ^ w_s0;
    assign w_csa1_maj = (w_s1 & r_win[9]) | (w_s1 & w_s0) | (r_win[9] & w_s0);
    assign w_csa1_car = w_csa1_maj << 1;

    assign w_csa2_sum = w_csa1_sum ^ w_csa1_car ^ r_win[0];
    assign w_csa2_maj = (w_csa1_sum & w_csa1_car) | (w_csa1_sum & r_win[0])
                      | (w_csa1_car & r_win[0]);
    assign w_csa2_car = w_csa2_maj << 1;

    assign w_new  = w_csa2_sum + w_csa2_car;
    assign w_fill = (r_state == c_ST_LOAD) ? bus.msg_word_i : w_new;

    // Window shifts down on every accepted load word or emitted schedule word
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 16; i++) begin
                r_win[i] <= '0;
            end
        end else if (w_load_hs || w_out_hs) begin
            for (int i = 0; i < 15; i++) begin
                r_win[i] <= r_win[i+1];
            end
            r_win[15] <= w_fill;
        end
    end

    // LOAD/EXPAND sequencing, round index and the end-of-block pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= c_ST_LOAD;
            r_load_cnt <= 4'd0;
            r_t        <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_abort) begin
                r_state    <= c_ST_LOAD;
                r_load_cnt <= 4'd0;
                r_t        <= '0;
            end else begin
                case (r_state)
                    c_ST_LOAD: begin
                        if (w_load_hs) begin
                            if (r_load_cnt == 4'd15) begin
                                r_load_cnt <= 4'd0;
                                r_t        <= '0;
                                r_state    <= c_ST_EXPAND;
                            end else begin
                                r_load_cnt <= r_load_cnt + 4'd1;
                            end
                        end
                    end
                    c_ST_EXPAND: begin
                        if (w_out_hs) begin
                            if (r_t == c_LAST_T) begin
                                r_t     <= '0;
                                r_state <= c_ST_LOAD;
                                r_done  <= 1'b1;
                            end else begin
                                r_t <= r_t + CNT_W'(1);
                            end
                        end
                    end
                    default: r_state <= c_ST_LOAD;
                endcase
            end
        end
    end

    assign bus.msg_ready_o = (r_state == c_ST_LOAD);
    assign bus.w_valid_o   = (r_state == c_ST_EXPAND);
    assign bus.busy_o      = (r_state == c_ST_EXPAND);
    assign bus.w_o         = r_win[0];
    assign bus.w_idx_o     = r_t;
    assign bus.done_o      = r_done;

endmodule
`default_nettype wire
